// File: rtl/tl_ul_pkg.sv
// ============================================================================
//  Module      : tl_ul_pkg
//  Description : Shared TL-UL types for the responder. Holds the A/D opcode
//                enums, the registered D-channel response struct, the largest
//                single-beat transfer size and an alignment helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tl_ul_pkg;

  // Largest legal a_size (log2 bytes) for a 32-bit single-beat link.
  localparam int MAX_SIZE = 2;

  // Storage width reserved for d_source inside the response struct. The top
  // level narrows it back to its own SOURCE_W.
  localparam int c_MAX_SOURCE_W = 8;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACCESS_ACK      = 3'd0,
    ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef struct packed {
    d_opcode_e                  opcode;
    logic [1:0]                 size;
    logic [c_MAX_SOURCE_W-1:0]  source;
    logic [31:0]                data;
    logic                       denied;
    logic                       corrupt;
  } rsp_t;

  // Natural alignment: the low a_size address bits must be zero. Sizes above
  // MAX_SIZE are never aligned on this link.
  function automatic logic is_aligned(input logic [1:0] addr_lsb,
                                      input logic [1:0] size);
    case (size)
      2'd0:    return 1'b1;
      2'd1:    return ~addr_lsb[0];
      2'd2:    return (addr_lsb == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_ul_responder_if.sv
// ============================================================================
//  Module      : tl_ul_responder_if
//  Description : TL-UL A and D channel bundle.
//  Ports       : master - drives a_* and d_ready, observes a_ready and d_*
//                slave  - drives a_ready and d_*, observes a_* and d_ready
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tl_ul_responder_if #(
  parameter int SOURCE_W = 2
);
  logic                 a_valid;
  logic                 a_ready;
  logic [2:0]           a_opcode;
  logic [2:0]           a_param;
  logic [1:0]           a_size;
  logic [SOURCE_W-1:0]  a_source;
  logic [31:0]          a_address;
  logic [3:0]           a_mask;
  logic [31:0]          a_data;

  logic                 d_valid;
  logic                 d_ready;
  logic [2:0]           d_opcode;
  logic [1:0]           d_param;
  logic [1:0]           d_size;
  logic [SOURCE_W-1:0]  d_source;
  logic [31:0]          d_data;
  logic                 d_denied;
  logic                 d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_data, d_denied, d_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_data, d_denied, d_corrupt,
    input  d_ready
  );
endinterface

`default_nettype wire

// File: rtl/tl_ul_resp_mem.sv
// ============================================================================
//  Module      : tl_ul_resp_mem
//  Description : DEPTH_WORDS x 32 single-port SRAM with per-byte write enable.
//                An enabled cycle with no byte enables is a read; the read
//                word is registered and held until the next read.
//  Ports       : clk     - clock
//                i_en    - access enable
//                i_we    - byte write enables (4'h0 = read)
//                i_addr  - word index
//                i_wdata - write data
//                o_rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_ul_resp_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic           clk,
  input  wire logic           i_en,
  input  wire logic [3:0]     i_we,
  input  wire logic [AW-1:0]  i_addr,
  input  wire logic [31:0]    i_wdata,
  output logic      [31:0]    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // No reset: contents and the read register are undefined after reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      if (i_we == 4'h0) begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/tl_ul_responder.sv
// ============================================================================
//  Module      : tl_ul_responder
//  Description : TL-UL manager endpoint. Accepts single-beat Get,
//                PutFullData and PutPartialData on channel A and answers
//                with AccessAckData / AccessAck on channel D, one cycle after
//                acceptance, from a word-addressed local SRAM.
//  Ports       : clock - sole clock
//                reset - asynchronous, active-high reset
//                tl    - TL-UL A/D channels (slave modport)
//  Options     : TL_RESP_STALL_EN - when defined, an 8-bit LFSR injects
//                a_ready backpressure whenever lfsr[1:0] == 2'b00.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_ul_responder
  import tl_ul_pkg::*;
#(
  parameter int          SOURCE_W    = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  wire logic           clock,
  input  wire logic           reset,
  tl_ul_responder_if.slave    tl
);

  localparam int          c_AW    = $clog2(DEPTH_WORDS);
  // Byte span, one bit wider so the compare cannot overflow.
  localparam logic [32:0] c_SPAN  = 33'(DEPTH_WORDS) << 2;
  localparam logic [0:0]  c_EMPTY = 1'b0;
  localparam logic [0:0]  c_FULL  = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  rsp_t        r_rsp;
  rsp_t        w_rsp_nxt;
  logic        r_from_mem;
  logic        w_d_valid;
  logic        w_stall;
  logic        w_accept;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_is_get;
  logic        w_is_put;
  logic        w_legal;
  logic [31:0] w_rdata;
  logic        w_unused;

  // ---------------------------------------------------------------- decode
  // Offset is taken modulo 2^32, so an address below BASE_ADDR wraps to a
  // huge offset and fails the range check before the index is truncated.
  assign w_offset   = tl.a_address - BASE_ADDR;
  assign w_in_range = ({1'b0, w_offset} < c_SPAN);
  assign w_is_get   = (tl.a_opcode == GET);
  assign w_is_put   = (tl.a_opcode == PUT_FULL) || (tl.a_opcode == PUT_PARTIAL);
  assign w_legal    = (w_is_get || w_is_put)
                    && (tl.a_size <= 2'(MAX_SIZE))
                    && is_aligned(tl.a_address[1:0], tl.a_size)
                    && w_in_range;

  // ------------------------------------------------------------ backpressure
`ifdef TL_RESP_STALL_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  // A slot frees up on the same edge the pending response drains.
  assign tl.a_ready = (~w_d_valid | tl.d_ready) & ~w_stall;
  // Reset level blocks acceptance even though a_ready reads high in reset.
  assign w_accept   = tl.a_valid & tl.a_ready & ~reset;

  // ------------------------------------------------------------------ SRAM
  tl_ul_resp_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (c_AW)
  ) u_mem (
    .clk     (clock),
    .i_en    (w_accept & w_legal),
    .i_we    ((w_accept & w_legal & w_is_put) ? tl.a_mask : 4'h0),
    .i_addr  (w_offset[c_AW+1:2]),
    .i_wdata (tl.a_data),
    .o_rdata (w_rdata)
  );

  // ------------------------------------------------------ response slot FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_EMPTY: if (w_accept) w_state_nxt = c_FULL;
      c_FULL: begin
        if (w_accept) begin
          w_state_nxt = c_FULL;
        end else if (tl.d_ready) begin
          w_state_nxt = c_EMPTY;
        end
      end
      default: w_state_nxt = c_EMPTY;
    endcase
  end

  always_comb begin
    w_d_valid = (r_state == c_FULL);
  end

  // ------------------------------------------------------ response payload
  always_comb begin
    w_rsp_nxt         = '0;
    w_rsp_nxt.opcode  = w_is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
    w_rsp_nxt.size    = tl.a_size;
    w_rsp_nxt.source  = c_MAX_SOURCE_W'(tl.a_source);
    w_rsp_nxt.data    = 32'h0;
    w_rsp_nxt.denied  = ~w_legal;
    w_rsp_nxt.corrupt = w_is_get & ~w_legal;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rsp      <= '0;
      r_from_mem <= 1'b0;
    end else if (w_accept) begin
      r_rsp      <= w_rsp_nxt;
      r_from_mem <= w_is_get & w_legal;
    end
  end

  // Read data lives in the SRAM output register, which only changes on an
  // accept, so it stays stable while the response is back-pressured.
  assign tl.d_valid   = w_d_valid;
  assign tl.d_opcode  = r_rsp.opcode;
  assign tl.d_param   = 2'b00;
  assign tl.d_size    = r_rsp.size;
  assign tl.d_source  = r_rsp.source[SOURCE_W-1:0];
  assign tl.d_data    = r_from_mem ? w_rdata : r_rsp.data;
  assign tl.d_denied  = r_rsp.denied;
  assign tl.d_corrupt = r_rsp.corrupt;

  assign w_unused = ^{tl.a_param, w_offset, r_rsp.source};

endmodule

`default_nettype wire

// File: tb/tb_tl_ul_responder.sv
// ============================================================================
//  Module      : tb_tl_ul_responder
//  Description : Self-checking bench for tl_ul_responder. A transaction-level
//                model (word array + expected-response queue) predicts every
//                D beat and the a_ready/d_valid handshake from the A beats it
//                sees accepted.
//  Options     : TL_RESP_STALL_EN - enables the LFSR backpressure model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_ul_responder;

  localparam int          c_SW    = 2;
  localparam logic [31:0] c_BASE  = 32'h8000_0000;
  localparam int          c_DEPTH = 1024;

  typedef struct packed {
    logic [2:0]      op;
    logic [1:0]      size;
    logic [c_SW-1:0] src;
    logic [31:0]     data;
    logic            den;
    logic            cor;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rnd_dready = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_resp = 0;
  int cyc = 0;

  logic [31:0] m_mem [c_DEPTH];
  exp_t        q[$];

  tl_ul_responder_if #(.SOURCE_W(c_SW)) tl ();

  tl_ul_responder #(
    .SOURCE_W    (c_SW),
    .BASE_ADDR   (c_BASE),
    .DEPTH_WORDS (c_DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tl    (tl)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef TL_RESP_STALL_EN
  logic [7:0] m_lfsr;
  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
  end
  function automatic bit model_stall();
    return (m_lfsr[1:0] == 2'b00);
  endfunction
`else
  function automatic bit model_stall();
    return 1'b0;
  endfunction
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_a_ready();
    return (q.size() == 0 || tl.d_ready) && !model_stall();
  endfunction

  // Apply one accepted A beat to the model and queue its expected response.
  task automatic model_accept();
    exp_t        e;
    logic [2:0]  op;
    int unsigned off;
    int unsigned idx;
    bit          legal;
    op    = tl.a_opcode;
    off   = tl.a_address - c_BASE;
    legal = (op == 3'd0 || op == 3'd1 || op == 3'd4) && (tl.a_size <= 2'd2)
            && ((tl.a_address % (32'd1 << tl.a_size)) == 0) && (off < 4 * c_DEPTH);
    idx   = off / 4;
    if (legal && op != 3'd4) begin
      for (int b = 0; b < 4; b++)
        if (tl.a_mask[b]) m_mem[idx][8*b +: 8] = tl.a_data[8*b +: 8];
    end
    e.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e.size = tl.a_size;
    e.src  = tl.a_source;
    e.data = (op == 3'd4 && legal) ? m_mem[idx] : 32'h0;
    e.den  = !legal;
    e.cor  = (op == 3'd4) && !legal;
    q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, i.e. what the next rising edge sees.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        q.delete();
      end else begin
        chk("d_valid", tl.d_valid, q.size() != 0);
        chk("a_ready", tl.a_ready, exp_a_ready());
        if (tl.d_valid && q.size() != 0) begin
          e = q[0];
          chk("rsp_ctl", {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_denied, tl.d_corrupt},
                         {e.op, 2'b00, e.size, e.src, e.den, e.cor});
          chk("rsp_data", tl.d_data, e.data);
          if (tl.d_ready) begin
            void'(q.pop_front());
            n_resp++;
          end
        end
        if (tl.a_valid && tl.a_ready) model_accept();
      end
    end
  end

  // Random d_ready while rnd_dready is set.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rnd_dready) tl.d_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [c_SW-1:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int n = 0;
    tl.a_opcode = op; tl.a_param = 3'd0; tl.a_size = sz; tl.a_source = src;
    tl.a_address = addr; tl.a_mask = mask; tl.a_data = data; tl.a_valid = 1'b1;
    @(negedge clock);
    while (!tl.a_ready && n < 200) begin n++; @(negedge clock); end
    if (!tl.a_ready) chk("a_accept_timeout", tl.a_ready, 1'b1);
    @(posedge clock);
    #1;
    tl.a_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    if (q.size() != 0) begin
      while (q.size() != 0 && n < 500) begin @(posedge clock); n++; end
      #1;
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    end
  endtask

  initial begin
    logic [2:0]  ops [10] = '{3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd7};
    logic [2:0]  op;
    logic [1:0]  sz;
    logic [31:0] addr;
    int          c0, r0, n, sel;

    tl.a_valid = 1'b0; tl.a_opcode = 3'd0; tl.a_param = 3'd0; tl.a_size = 2'd0;
    tl.a_source = '0; tl.a_address = '0; tl.a_mask = 4'h0; tl.a_data = '0;
    tl.d_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_d_valid", tl.d_valid, 1'b0);
    chk("rst_d_fields", {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_denied, tl.d_corrupt}, '0);
    chk("rst_d_data", tl.d_data, 32'h0);
    chk("rst_a_ready", tl.a_ready, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    tl.d_ready = 1'b1;

    // Give every word a known value.
    for (int i = 0; i < c_DEPTH; i++)
      send(3'd0, 2'd2, c_SW'(i), c_BASE + 32'(4 * i), 4'hF, $urandom);
    drain();

    // Directed cases.
    send(3'd0, 2'd2, 2'd1, 32'h8000_0010, 4'hF, 32'hDEADBEEF);
    chk("put_valid", tl.d_valid, 1'b1);
    chk("put_op_src_den", {tl.d_opcode, tl.d_source, tl.d_denied}, {3'd0, 2'd1, 1'b0});
    send(3'd4, 2'd2, 2'd0, 32'h8000_0010, 4'h0, 32'h0);
    chk("get_op", tl.d_opcode, 3'd1);
    chk("get_data", tl.d_data, 32'hDEADBEEF);
    send(3'd1, 2'd2, 2'd2, 32'h8000_0010, 4'h5, 32'h11223344);
    send(3'd4, 2'd2, 2'd2, 32'h8000_0010, 4'hF, 32'h0);
    chk("partial_data", tl.d_data, 32'hDE22BE44);
    send(3'd4, 2'd2, 2'd3, 32'h9000_0000, 4'hF, 32'h0);
    chk("oor_den_cor_data", {tl.d_denied, tl.d_corrupt, tl.d_data}, {1'b1, 1'b1, 32'h0});
    send(3'd2, 2'd2, 2'd1, 32'h8000_0010, 4'hF, 32'h0BAD0BAD);
    chk("op2_op_den", {tl.d_opcode, tl.d_denied, tl.d_corrupt}, {3'd0, 1'b1, 1'b0});
    send(3'd4, 2'd2, 2'd1, 32'h8000_0010, 4'hF, 32'h0);
    chk("op2_no_write", tl.d_data, 32'hDE22BE44);
    send(3'd4, 2'd2, 2'd0, 32'h8000_0002, 4'hF, 32'h0);
    chk("misalign_den", tl.d_denied, 1'b1);
    send(3'd4, 2'd1, 2'd0, 32'h8000_0002, 4'hF, 32'h0);
    chk("half_legal_den", tl.d_denied, 1'b0);
    send(3'd4, 2'd2, 2'd0, 32'h7FFF_FFFC, 4'hF, 32'h0);
    chk("wrap_den", tl.d_denied, 1'b1);
    drain();

    // Backpressure: response held, next A beat stalled, then same-cycle swap.
    tl.d_ready = 1'b0;
    send(3'd4, 2'd2, 2'd2, c_BASE + 32'h20, 4'hF, 32'h0);
    tl.a_opcode = 3'd4; tl.a_address = c_BASE + 32'h24; tl.a_source = 2'd3; tl.a_valid = 1'b1;
    repeat (5) begin @(negedge clock); chk("stall_a_ready", tl.a_ready, 1'b0); end
    @(posedge clock); #1;
    tl.d_ready = 1'b1;
    @(negedge clock);
    chk("release_a_ready", tl.a_ready, exp_a_ready());
    n = 0;
    while (!tl.a_ready && n < 50) begin @(negedge clock); n++; end
    @(posedge clock); #1;
    tl.a_valid = 1'b0;
    drain();

    // 100 back-to-back Gets.
    c0 = cyc; r0 = n_resp;
    for (int i = 0; i < 100; i++)
      send(3'd4, 2'd2, c_SW'(i), c_BASE + 32'(4 * i), 4'hF, 32'h0);
    while (q.size() != 0 && cyc - c0 < 1000) @(posedge clock);
    #1;
    chk("b2b_resps", n_resp - r0, 100);
`ifndef TL_RESP_STALL_EN
    chk("b2b_cycles", cyc - c0, 101);
`endif

    // Reset while a response is pending and a Put is presented.
    tl.d_ready = 1'b0;
    send(3'd4, 2'd2, 2'd0, c_BASE + 32'h30, 4'hF, 32'h0);
    tl.a_opcode = 3'd0; tl.a_size = 2'd2; tl.a_address = c_BASE + 32'h34;
    tl.a_mask = 4'hF; tl.a_data = 32'hCAFEF00D; tl.a_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_dvalid", tl.d_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    tl.a_valid = 1'b0;
    tl.d_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    send(3'd4, 2'd2, 2'd0, c_BASE + 32'h34, 4'hF, 32'h0);
    chk("rst_no_write", tl.d_data, m_mem[13]);
    drain();

    // Random traffic with random d_ready.
    rnd_dready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      op  = ops[$urandom_range(0, 9)];
      sz  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      sel = $urandom_range(0, 9);
      if (sel < 8)
        addr = c_BASE + 32'(4 * (($urandom_range(0, 1) == 1) ? $urandom_range(0, 15)
                                                              : $urandom_range(0, c_DEPTH - 1)))
               + 32'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : 0);
      else if (sel == 8)
        addr = c_BASE + 32'(4 * c_DEPTH) + 32'($urandom_range(0, 64));
      else
        addr = $urandom;
      send(op, sz, c_SW'($urandom_range(0, 3)), addr, 4'($urandom_range(0, 15)), $urandom);
    end
    rnd_dready = 1'b0;
    @(posedge clock); #1;
    tl.d_ready = 1'b1;
    drain();
    repeat (2) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
